// File: rtl/player_iter.sv
// player_iter -- iterative PRESENT-family P-layer engine.
//
// Applies the bit permutation P (or its inverse) to a W-bit block k times,
// one application per clock. A block is taken in through a valid/ready
// handshake, permuted in place, then held on the output until it is taken.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   engine idle and able to accept (registered)
//   in_block   block to permute (W bits)
//   in_inv     0 = forward P, 1 = inverse P^-1 (sampled at acceptance)
//   in_count   number of applications k (sampled at acceptance)
//   out_valid  result present (registered)
//   out_ready  consumer takes the result
//   out_block  result, equal to the data register at all times
//   busy       high while running or holding a result
module player_iter #(
    parameter int W     = 64,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_block,
    input  logic             in_inv,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_block,
    output logic             busy
);

    localparam int G = W / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       dreg;
    logic [CNT_W-1:0]   cnt;
    logic               inv_q;
    logic               load;
    logic               step;
    logic [W-1:0]       fwd_perm;
    logic [W-1:0]       inv_perm;

    // Pure wiring: forward sends bit i to (i*G) mod (W-1), inverse sends
    // bit j to (j*4) mod (W-1). The top bit is a fixed point of both.
    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_perm
            localparam int FWD_DST = (gi * G) % (W - 1);
            localparam int INV_DST = (gi * 4) % (W - 1);
            assign fwd_perm[FWD_DST] = dreg[gi];
            assign inv_perm[INV_DST] = dreg[gi];
        end
    endgenerate
    assign fwd_perm[W-1] = dreg[W-1];
    assign inv_perm[W-1] = dreg[W-1];

    // Next-state logic
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = (in_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // Exit on the last application so the counter never wraps.
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dreg      <= '0;
            cnt       <= '0;
            inv_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            // Handshake flags are registered copies of the next-state decode.
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (load) begin
                dreg  <= in_block;
                cnt   <= in_count;
                inv_q <= in_inv;
            end else if (step) begin
                dreg <= inv_q ? inv_perm : fwd_perm;
                cnt  <= cnt - CNT_W'(1);
            end
        end
    end

    assign out_block = dreg;
    assign busy      = (state != IDLE);

endmodule
